outport_arbiter: RTL

- Per-output-port scheduler for the chiplet switch. Shares one crossbar output among NUM_BUFFERS input buffers using round-robin arbitration with wormhole packet locking.
- Tracks downstream credits per virtual channel and only forwards a flit when its target VC has a credit.
- Drives the crossbar select/enable for its port. One instance per output port (NUM_LINKS+1 instances in the switch).

---
 rtl/outport_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/outport_arbiter.sv
// outport_arbiter: per-output-port scheduler for the chiplet switch.
// Shares one crossbar output among NUM_BUFFERS input buffers with round-robin arbitration and
// wormhole locking: once a head flit wins, only that buffer may use the port until its tail.
// A flit is only forwarded when its downstream VC has a credit.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req             per-buffer head flit valid and routed here
//   req_vc          per-buffer downstream VC of the head flit (VC_W bits each)
//   req_tail        per-buffer head flit is a packet tail
//   credit_return   one credit returned per asserted VC bit
//   grant           one-hot pop strobe to the buffers
//   sel, enable     crossbar select index and output enable
//   locked          a packet currently owns the port
//   owner_vc        VC held by the current owner (0 when unlocked)
//   credit_count    current credits per VC (CNT_W bits each, VC0 in the low bits)
//   credit_err      sticky: credit returned to a full counter
module outport_arbiter #(
   parameter int NUM_BUFFERS = 5,
   parameter int NUM_VCS     = 2,
   parameter int CREDIT_MAX  = 8,
   parameter int SEL_W       = $clog2(NUM_BUFFERS),
   parameter int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   parameter int CNT_W       = $clog2(CREDIT_MAX + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_BUFFERS-1:0]   req,
   input  logic [NUM_BUFFERS*VC_W-1:0] req_vc,
   input  logic [NUM_BUFFERS-1:0]   req_tail,
   input  logic [NUM_VCS-1:0]       credit_return,
   output logic [NUM_BUFFERS-1:0]   grant,
   output logic [SEL_W-1:0]         sel,
   output logic                     enable,
   output logic                     locked,
   output logic [VC_W-1:0]          owner_vc,
   output logic [NUM_VCS*CNT_W-1:0] credit_count,
   output logic                     credit_err
);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [SEL_W-1:0]  owner_q, owner_d;
   logic [VC_W-1:0]   owner_vc_q, owner_vc_d;
   logic [CNT_W-1:0]  credit_q [NUM_VCS];
   logic [CNT_W-1:0]  credit_d [NUM_VCS];
   logic              credit_err_q, credit_err_d;

   logic [(1<<VC_W)-1:0] vc_ok;      // VC has at least one credit; out-of-range ids never ok
   logic [NUM_BUFFERS-1:0] eligible;
   logic              found;
   logic [SEL_W-1:0]  win;
   logic [VC_W-1:0]   gnt_vc;

   function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] p);
      return (int'(p) == NUM_BUFFERS - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      vc_ok = '0;
      for (int v = 0; v < NUM_VCS; v++) vc_ok[v] = |credit_q[v];
      for (int i = 0; i < NUM_BUFFERS; i++) eligible[i] = req[i] && vc_ok[req_vc[i*VC_W +: VC_W]];
   end

   // First eligible requester at or after rr_ptr, wrapping at NUM_BUFFERS
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_BUFFERS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_BUFFERS) idx = idx - NUM_BUFFERS;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            win   = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      owner_vc_d = owner_vc_q;
      grant      = '0;
      sel        = '0;
      enable     = 1'b0;
      gnt_vc     = '0;
      case (state_q)
         StIdle: begin
            if (found) begin
               grant[win] = 1'b1;
               sel        = win;
               enable     = 1'b1;
               gnt_vc     = req_vc[win*VC_W +: VC_W];
               if (req_tail[win]) begin
                  rr_ptr_d = next_idx(win);
               end else begin
                  state_d    = StLocked;
                  owner_d    = win;
                  owner_vc_d = gnt_vc;
               end
            end
         end
         StLocked: begin
            // Body flits travel on the VC latched from the head; req_vc is ignored here
            if (req[owner_q] && vc_ok[owner_vc_q]) begin
               grant[owner_q] = 1'b1;
               sel            = owner_q;
               enable         = 1'b1;
               gnt_vc         = owner_vc_q;
               if (req_tail[owner_q]) begin
                  state_d  = StIdle;
                  rr_ptr_d = next_idx(owner_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (rst) begin
         grant  = '0;
         sel    = '0;
         enable = 1'b0;
      end
   end

   always_comb begin
      logic dec, inc;
      dec          = 1'b0;
      inc          = 1'b0;
      credit_err_d = credit_err_q;
      for (int v = 0; v < NUM_VCS; v++) begin
         dec         = enable && (int'(gnt_vc) == v);
         inc         = credit_return[v];
         credit_d[v] = credit_q[v];
         if (dec && !inc) begin
            credit_d[v] = credit_q[v] - 1'b1;
         end else if (inc && !dec) begin
            if (credit_q[v] == CNT_W'(CREDIT_MAX)) credit_err_d = 1'b1;
            else credit_d[v] = credit_q[v] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         owner_vc_q   <= '0;
         credit_err_q <= 1'b0;
         for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CNT_W'(CREDIT_MAX);
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         owner_vc_q   <= owner_vc_d;
         credit_err_q <= credit_err_d;
         for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= credit_d[v];
      end
   end

   always_comb begin
      credit_count = '0;
      for (int v = 0; v < NUM_VCS; v++) credit_count[v*CNT_W +: CNT_W] = credit_q[v];
   end

   assign locked     = (state_q == StLocked) && !rst;
   assign owner_vc   = locked ? owner_vc_q : '0;
   assign credit_err = credit_err_q;

endmodule
